avaliador_desvio: RTL and testbench
===================================

// Module: avaliador_desvio
// PURPOSE
//  Consumer side of the flags interface: holds the latest z/c/s/o snapshot written by the ALU,
//  accepts conditional-jump requests from the decoder, waits until any in-flight ALU op has
//  delivered its flags, evaluates the condition and drives a PC-load handshake when taken.
//  Sits between the flags register output, the instruction decoder and the program counter.
// PARAMETERS
//  ADDR_W   16  width of jump target / PC address
//  TIMEOUT  16  max cycles spent in WAIT for flags before aborting (>=2)
// PORTS
//  clk          in   1       single clock, rising edge
//  r            in   1       reset, asynchronous, active-high
//  alu_issue    in   1       ALU op that will update flags issued this cycle
//  flags_valid  in   1       flagsI carries new flags this cycle
//  flagsI       in   4       {o,s,c,z}: bit0 z, bit1 c, bit2 s, bit3 o
//  jmp_valid    in   1       decoder presents a jump request
//  jmp_ready    out  1       block can accept a request (IDLE only)
//  jmp_cond     in   4       condition code, see BEHAVIOUR
//  jmp_target   in   ADDR_W  jump destination
//  pc_load      out  1       request PC to load pc_target; held until pc_ack
//  pc_ack       in   1       PC has loaded pc_target
//  pc_target    out  ADDR_W  latched jump destination
//  done         out  1       one-cycle pulse: request resolved
//  taken        out  1       valid with done: 1 = jump taken
//  err          out  1       valid with done: reserved cond code or flags timeout
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-jump): state IDLE, pending=0, flags_q=0, wait_cnt=0;
//    jmp_ready=1 after reset release, pc_load=done=taken=err=0, pc_target=0.
//  - pending: set on alu_issue, cleared on flags_valid; both same cycle -> stays 1.
//    flags_q <= flagsI on flags_valid.
//  - Cond codes: 0000 always, 0001 z, 0010 !z, 0011 c, 0100 !c, 0101 s, 0110 !s, 0111 o,
//    1000 !o; 1001..1111 reserved -> not taken, err=1.
//  - FSM IDLE/WAIT/EVAL/LOAD/DONE; all outputs Moore-decoded from registered state.
//    IDLE: jmp_ready=1; jmp_valid -> latch cond,target; go WAIT if pending or alu_issue
//      this cycle (and not cleared this cycle without new issue), else EVAL.
//    WAIT: wait_cnt++; flags_valid with no alu_issue -> EVAL (flags_q updated same edge);
//      wait_cnt==TIMEOUT-1 -> DONE with err=1, taken=0; wait_cnt cleared on exit.
//    EVAL: evaluate on flags_q; taken & legal -> LOAD, else DONE (taken=0).
//    LOAD: pc_load=1, pc_target stable; pc_ack -> DONE with taken=1. No timeout here.
//    DONE: done=1 for exactly one cycle, taken/err valid; -> IDLE.
//  - Latency, no pending: accept at edge 0, EVAL cycle 1, pc_load high cycle 2; with
//    immediate pc_ack, done cycle 3. Not taken: done cycle 2.
//  - jmp_valid outside IDLE ignored (jmp_ready=0); decoder must hold request.
//  - flags_valid/alu_issue tracked in every state; jump sees flags of the last op issued
//    before or with its acceptance.
// STRUCTURE
//  - Shared include: cond code `defines, flag bit indices (Z=0,C=1,S=2,O=3), FSM encoding.
//  - Sub-module avaliador_cond: combinational (cond, flags) -> {taken, illegal}.
//  - Top: pending/flags_q regs, wait counter, FSM, output regs.
// TESTING
//  - flags_q z=1, no pending; jmp cond=0001 target=0x00A5 -> pc_load cycle 2, pc_target=0x00A5,
//    pc_ack -> done=1 taken=1 err=0.
//  - z=0, cond=0001 -> no pc_load, done cycle 2 taken=0; cond=0010 -> taken=1.
//  - alu_issue then jmp next cycle; flags_valid c=1 three cycles later; cond=0011 -> WAIT 3
//    cycles, then taken=1; flags before that ignored.
//  - pending, no flags_valid, TIMEOUT=16 -> done after 16 WAIT cycles, err=1, taken=0.
//  - cond=1011 -> done, taken=0, err=1; cond=0000 with flags=0 -> taken=1.
//  - r asserted while in LOAD with pc_ack low -> pc_load=0 immediately, jmp_ready=1 after release.

Source files
------------

// File: rtl/avaliador_desvio_pkg.sv
// Shared definitions for the branch evaluator.
//   - flag bit positions inside the {o,s,c,z} snapshot
//   - condition code encodings understood by avaliador_cond
//   - FSM state encoding used by avaliador_desvio
package avaliador_desvio_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_O = 3;

    localparam logic [3:0] COND_ALWAYS = 4'b0000;
    localparam logic [3:0] COND_Z      = 4'b0001;
    localparam logic [3:0] COND_NZ     = 4'b0010;
    localparam logic [3:0] COND_C      = 4'b0011;
    localparam logic [3:0] COND_NC     = 4'b0100;
    localparam logic [3:0] COND_S      = 4'b0101;
    localparam logic [3:0] COND_NS     = 4'b0110;
    localparam logic [3:0] COND_O      = 4'b0111;
    localparam logic [3:0] COND_NO     = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_EVAL = 3'd2,
        S_LOAD = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/avaliador_cond.sv
// Combinational condition evaluator.
// Ports:
//   cond_i     condition code
//   flags_i    {o,s,c,z} flag snapshot
//   taken_o    condition holds (always 0 for reserved codes)
//   illegal_o  condition code is reserved (1001..1111)
module avaliador_cond (
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       taken_o,
    output logic       illegal_o
);
    import avaliador_desvio_pkg::*;

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (cond_i)
            COND_ALWAYS: taken_o = 1'b1;
            COND_Z:      taken_o =  flags_i[FLAG_Z];
            COND_NZ:     taken_o = ~flags_i[FLAG_Z];
            COND_C:      taken_o =  flags_i[FLAG_C];
            COND_NC:     taken_o = ~flags_i[FLAG_C];
            COND_S:      taken_o =  flags_i[FLAG_S];
            COND_NS:     taken_o = ~flags_i[FLAG_S];
            COND_O:      taken_o =  flags_i[FLAG_O];
            COND_NO:     taken_o = ~flags_i[FLAG_O];
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/avaliador_desvio.sv
// Conditional-jump evaluator sitting between the ALU flags, the decoder and the PC.
// Holds the latest flag snapshot, waits for an in-flight ALU op to deliver its flags,
// evaluates the jump condition and drives a PC-load handshake when the jump is taken.
// Ports:
//   clk, r                         clock / async active-high reset
//   alu_issue, flags_valid, flagsI flags producer side
//   jmp_valid, jmp_ready,
//   jmp_cond, jmp_target           decoder request handshake
//   pc_load, pc_ack, pc_target     PC load handshake
//   done, taken, err               one-cycle resolution report
module avaliador_desvio #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              r,
    input  logic              alu_issue,
    input  logic              flags_valid,
    input  logic [3:0]        flagsI,
    input  logic              jmp_valid,
    output logic              jmp_ready,
    input  logic [3:0]        jmp_cond,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic              pc_load,
    input  logic              pc_ack,
    output logic [ADDR_W-1:0] pc_target,
    output logic              done,
    output logic              taken,
    output logic              err
);
    import avaliador_desvio_pkg::*;

    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q;
    logic [3:0]        flags_q, flags_d;
    logic              pending_q, pending_d;
    logic [3:0]        cond_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [ADDR_W-1:0] pc_target_q;
    logic              ready_q, pc_load_q, done_q, taken_q, err_q;
    logic              c_taken, c_illegal;

    // A new issue wins over a flags delivery in the same cycle: the delivered
    // flags belong to an older op, the newly issued one is still outstanding.
    assign pending_d = alu_issue ? 1'b1 : (flags_valid ? 1'b0 : pending_q);
    assign flags_d   = flags_valid ? flagsI : flags_q;

    avaliador_cond u_cond (
        .cond_i    (cond_q),
        .flags_i   (flags_q),
        .taken_o   (c_taken),
        .illegal_o (c_illegal)
    );

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            pending_q <= 1'b0;
            flags_q   <= 4'b0;
        end else begin
            pending_q <= pending_d;
            flags_q   <= flags_d;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q     <= S_IDLE;
            cond_q      <= 4'b0;
            wait_cnt_q  <= '0;
            pc_target_q <= '0;
            ready_q     <= 1'b1;
            pc_load_q   <= 1'b0;
            done_q      <= 1'b0;
            taken_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (jmp_valid) begin
                        cond_q      <= jmp_cond;
                        pc_target_q <= jmp_target;
                        ready_q     <= 1'b0;
                        // pending_d already folds in this cycle's issue/delivery
                        state_q     <= pending_d ? S_WAIT : S_EVAL;
                    end
                end
                S_WAIT: begin
                    if (flags_valid && !alu_issue) begin
                        // flags_q takes the new snapshot on this same edge
                        wait_cnt_q <= '0;
                        state_q    <= S_EVAL;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        wait_cnt_q <= '0;
                        done_q     <= 1'b1;
                        taken_q    <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_EVAL: begin
                    if (c_taken && !c_illegal) begin
                        pc_load_q <= 1'b1;
                        state_q   <= S_LOAD;
                    end else begin
                        done_q  <= 1'b1;
                        taken_q <= 1'b0;
                        err_q   <= c_illegal;
                        state_q <= S_DONE;
                    end
                end
                S_LOAD: begin
                    if (pc_ack) begin
                        pc_load_q <= 1'b0;
                        done_q    <= 1'b1;
                        taken_q   <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    taken_q <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q   <= 1'b1;
                    pc_load_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign jmp_ready = ready_q;
    assign pc_load   = pc_load_q;
    assign pc_target = pc_target_q;
    assign done      = done_q;
    assign taken     = taken_q;
    assign err       = err_q;

endmodule

// File: tb/tb_avaliador_desvio.sv
module tb_avaliador_desvio;

    logic        clk, r;
    logic        alu_issue, flags_valid, jmp_valid, pc_ack;
    logic [3:0]  flagsI, jmp_cond;
    logic [15:0] jmp_target;
    logic        jmp_ready, pc_load, done, taken, err;
    logic [15:0] pc_target;

    int errors = 0;
    int checks = 0;

    avaliador_desvio #(.ADDR_W(16), .TIMEOUT(16)) dut (
        .clk         (clk),
        .r           (r),
        .alu_issue   (alu_issue),
        .flags_valid (flags_valid),
        .flagsI      (flagsI),
        .jmp_valid   (jmp_valid),
        .jmp_ready   (jmp_ready),
        .jmp_cond    (jmp_cond),
        .jmp_target  (jmp_target),
        .pc_load     (pc_load),
        .pc_ack      (pc_ack),
        .pc_target   (pc_target),
        .done        (done),
        .taken       (taken),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        flags_valid = 1'b1;
        flagsI      = f;
        tick();
        flags_valid = 1'b0;
        flagsI      = 4'h0;
    endtask

    // Jump with nothing pending: EVAL in cycle 1, pc_load or done in cycle 2.
    task automatic run_jump(input string tag, input logic [3:0] c, input logic [15:0] tgt,
                            input logic exp_taken, input logic exp_err);
        jmp_valid  = 1'b1;
        jmp_cond   = c;
        jmp_target = tgt;
        tick();                                   // edge 0: accept
        jmp_valid = 1'b0;
        check({tag, "_busy"}, jmp_ready, 0);
        check({tag, "_c1_pcload"}, pc_load, 0);
        tick();                                   // edge 1
        if (exp_taken) begin
            check({tag, "_pcload"}, pc_load, 1);
            check({tag, "_target"}, pc_target, tgt);
            check({tag, "_c2_done"}, done, 0);
            pc_ack = 1'b1;
            tick();                               // edge 2
            pc_ack = 1'b0;
            check({tag, "_pcload_drop"}, pc_load, 0);
        end else begin
            check({tag, "_pcload"}, pc_load, 0);
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_taken"}, taken, exp_taken);
        check({tag, "_err"}, err, exp_err);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_ready"}, jmp_ready, 1);
    endtask

    initial begin
        int n;
        r = 1'b1; alu_issue = 1'b0; flags_valid = 1'b0; flagsI = 4'h0;
        jmp_valid = 1'b0; jmp_cond = 4'h0; jmp_target = 16'h0; pc_ack = 1'b0;
        tick(); tick();
        r = 1'b0;
        tick();
        check("rst_ready", jmp_ready, 1);
        check("rst_pcload", pc_load, 0);
        check("rst_done", done, 0);
        check("rst_taken", taken, 0);
        check("rst_err", err, 0);
        check("rst_target", pc_target, 16'h0);

        // z=1, jz taken to 0x00A5
        set_flags(4'b0001);
        run_jump("jz_t", 4'b0001, 16'h00A5, 1'b1, 1'b0);

        // z=0: jz not taken, jnz taken
        set_flags(4'b0000);
        run_jump("jz_nt", 4'b0001, 16'h0100, 1'b0, 1'b0);
        run_jump("jnz_t", 4'b0010, 16'h0200, 1'b1, 1'b0);

        // issue, then jc next cycle; stale c=0 must not be used
        alu_issue = 1'b1;
        tick();
        alu_issue  = 1'b0;
        jmp_valid  = 1'b1;
        jmp_cond   = 4'b0011;
        jmp_target = 16'h1234;
        tick();                                   // accepted into WAIT
        jmp_valid = 1'b0;
        check("wait_busy", jmp_ready, 0);
        tick();
        check("wait_c2_pcload", pc_load, 0);
        check("wait_c2_done", done, 0);
        tick();
        check("wait_c3_pcload", pc_load, 0);
        check("wait_c3_done", done, 0);
        flags_valid = 1'b1;
        flagsI      = 4'b0010;
        tick();                                   // -> EVAL, flags_q has c=1
        flags_valid = 1'b0;
        flagsI      = 4'h0;
        check("wait_eval_pcload", pc_load, 0);
        tick();
        check("wait_pcload", pc_load, 1);
        check("wait_target", pc_target, 16'h1234);
        pc_ack = 1'b1;
        tick();
        pc_ack = 1'b0;
        check("wait_done", done, 1);
        check("wait_taken", taken, 1);
        check("wait_err", err, 0);
        tick();
        check("wait_ready", jmp_ready, 1);

        // timeout: op issued, flags never come
        alu_issue = 1'b1;
        tick();
        alu_issue  = 1'b0;
        jmp_valid  = 1'b1;
        jmp_cond   = 4'b0000;
        jmp_target = 16'h0F0F;
        tick();                                   // accepted into WAIT
        jmp_valid = 1'b0;
        n = 0;
        while (n < 40 && done !== 1'b1) begin
            tick();
            n++;
        end
        check("to_cycles", n, 16);
        check("to_taken", taken, 0);
        check("to_err", err, 1);
        check("to_pcload", pc_load, 0);
        tick();
        check("to_done_pulse", done, 0);
        check("to_ready", jmp_ready, 1);

        // deliver the outstanding flags (all zero) to clear pending
        set_flags(4'b0000);

        // reserved code, then unconditional with flags=0
        run_jump("rsvd", 4'b1011, 16'h0333, 1'b0, 1'b1);
        run_jump("always", 4'b0000, 16'h0444, 1'b1, 1'b0);

        // s=1 / o=0 patterns
        set_flags(4'b0100);
        run_jump("js_t", 4'b0101, 16'h0555, 1'b1, 1'b0);
        run_jump("jno_t", 4'b1000, 16'h0666, 1'b1, 1'b0);
        run_jump("jc_nt", 4'b0011, 16'h0777, 1'b0, 1'b0);

        // reset while in LOAD without ack
        jmp_valid  = 1'b1;
        jmp_cond   = 4'b0000;
        jmp_target = 16'hBEEF;
        tick();
        jmp_valid = 1'b0;
        tick();
        check("rl_pcload", pc_load, 1);
        r = 1'b1;
        #1;
        check("rl_pcload_clr", pc_load, 0);
        check("rl_target_clr", pc_target, 16'h0);
        tick();
        r = 1'b0;
        tick();
        check("rl_ready", jmp_ready, 1);
        check("rl_done", done, 0);
        check("rl_pcload_after", pc_load, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
